// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of one shared memory slave (m0 = instruction bus, m1 = data bus).
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise m1 has fixed priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e state_q;
  logic   pick_m1;

`ifdef MEM_ARB_RR_EN
  // Remembers who was granted last; m1 after reset so m0 wins the first tie.
  logic last_m1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_m1_q <= 1'b1;
    end else if (state_q == StIdle && (m0_valid || m1_valid)) begin
      last_m1_q <= pick_m1;
    end
  end

  assign pick_m1 = m1_valid && (!m0_valid || !last_m1_q);
`else
  assign pick_m1 = m1_valid;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grant   <= 2'b00;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_m1) begin
            state_q <= StGnt1;
            grant   <= 2'b10;
          end else if (m0_valid) begin
            state_q <= StGnt0;
            grant   <= 2'b01;
          end
        end
        // Ownership ends only on the slave completion pulse; no preemption.
        StGnt0, StGnt1: begin
          if (s_ready) begin
            state_q <= StIdle;
            grant   <= 2'b00;
          end
        end
        default: begin
          state_q <= StIdle;
          grant   <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    case (state_q)
      StGnt0: begin
        s_valid = m0_valid;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end
      StGnt1: begin
        s_valid = m1_valid;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end
      default: ;
    endcase
  end

  // Spurious s_ready in idle falls through here with both readies low.
  assign m0_ready = (state_q == StGnt0) && s_ready;
  assign m1_ready = (state_q == StGnt1) && s_ready;
  assign m0_rdata = m0_ready ? s_rdata : '0;
  assign m1_rdata = m1_ready ? s_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random masters, a latency-randomised slave, and a scoreboard monitor
// that predicts grants and responses from the arbitration rules.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          mv     [2];
  logic [AW-1:0] maddr  [2];
  logic [DW-1:0] mwdata [2];
  logic [SW-1:0] mwstrb [2];
  logic [DW-1:0] m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic          m0_ready, m1_ready, s_valid, s_ready;
  logic [AW-1:0] s_addr;
  logic [SW-1:0] s_wstrb;
  logic [1:0]    grant;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_valid (mv[0]),
    .m0_addr  (maddr[0]),
    .m0_wdata (mwdata[0]),
    .m0_wstrb (mwstrb[0]),
    .m0_rdata (m0_rdata),
    .m0_ready (m0_ready),
    .m1_valid (mv[1]),
    .m1_addr  (maddr[1]),
    .m1_wdata (mwdata[1]),
    .m1_wstrb (mwstrb[1]),
    .m1_rdata (m1_rdata),
    .m1_ready (m1_ready),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .grant    (grant)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] a, input logic [31:0] d);
    return (a * 32'h9E3779B1) ^ {d[15:0], d[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  // Slave behaviour knobs, written only by the main stimulus block.
  int          fixed_lat = -1;
  bit          ovr_en    = 1'b0;
  logic [31:0] ovr_data  = '0;
  int          spur_req  = 0;
  int          spur_done = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [1:0]  glog[$];

  // Slave: completes each request a chosen number of cycles after s_valid first appears.
  initial begin
    int cnt;
    int tgt;
    bit busy;
    s_ready = 1'b0;
    s_rdata = '0;
    cnt = 0;
    tgt = 0;
    busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_ready = 1'b0;
      s_rdata = $urandom;
      if (spur_req != spur_done) begin
        spur_done++;
        if (!s_valid) s_ready = 1'b1;
      end else if (s_valid) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          tgt  = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 4);
        end
        if (cnt >= tgt) begin
          s_ready = 1'b1;
          s_rdata = ovr_en ? ovr_data : slave_data(s_addr, s_wdata);
          busy    = 1'b0;
        end else begin
          cnt++;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // Monitor: predicts the owner from last cycle's requests and checks every output.
  logic [1:0] m_owner = 2'b00;
  logic [1:0] pdg = 2'b00;
  bit pv0 = 1'b0, pv1 = 1'b0, psr = 1'b0, mlast = 1'b1;

  always @(negedge clk) begin
    logic [1:0] eg;
    bit r0, r1;
    if (!rst) begin
      check("reset_ctrl", {grant, s_valid, m0_ready, m1_ready}, 0);
      check("reset_rdata", m0_rdata | m1_rdata, 0);
      eg    = 2'b00;
      mlast = 1'b1;
    end else begin
      if (m_owner == 2'b00) begin
        if (pv0 && pv1)  eg = RR ? (mlast ? 2'b01 : 2'b10) : 2'b10;
        else if (pv0)    eg = 2'b01;
        else if (pv1)    eg = 2'b10;
        else             eg = 2'b00;
        if (eg != 2'b00) mlast = (eg == 2'b10);
      end else begin
        eg = psr ? 2'b00 : m_owner;
      end
      check("grant", grant, eg);
      if (grant != 2'b00 && pdg == 2'b00) glog.push_back(grant);
      if (eg == 2'b01) begin
        check("s_fields_m0", {s_valid, s_addr, s_wdata, s_wstrb},
              {mv[0], maddr[0], mwdata[0], mwstrb[0]});
      end else if (eg == 2'b10) begin
        check("s_fields_m1", {s_valid, s_addr, s_wdata, s_wstrb},
              {mv[1], maddr[1], mwdata[1], mwstrb[1]});
      end else begin
        check("s_valid_idle", s_valid, 0);
      end
      r0 = (eg == 2'b01) && s_ready;
      r1 = (eg == 2'b10) && s_ready;
      check("m0_ready", m0_ready, r0);
      check("m1_ready", m1_ready, r1);
      if (r0 && m0_ready) begin
        if (q0.size() == 0) check("m0_resp_unexpected", 1, 0);
        else check("m0_rdata", m0_rdata, q0.pop_front());
      end else begin
        check("m0_rdata_zero", m0_rdata, 0);
      end
      if (r1 && m1_ready) begin
        if (q1.size() == 0) check("m1_resp_unexpected", 1, 0);
        else check("m1_rdata", m1_rdata, q1.pop_front());
      end else begin
        check("m1_rdata_zero", m1_rdata, 0);
      end
    end
    m_owner = eg;
    pv0     = mv[0];
    pv1     = mv[1];
    psr     = s_ready;
    pdg     = grant;
  end

  // Called at posedge+1; returns at posedge+1 after the ready cycle with valid dropped.
  task automatic do_txn(input int id, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st);
    int n;
    bit got;
    maddr[id]  = a;
    mwdata[id] = d;
    mwstrb[id] = st;
    mv[id]     = 1'b1;
    if (id == 0) q0.push_back(ovr_en ? ovr_data : slave_data(a, d));
    else         q1.push_back(ovr_en ? ovr_data : slave_data(a, d));
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      got = (id == 0) ? m0_ready : m1_ready;
    end
    check((id == 0) ? "m0_txn_done" : "m1_txn_done", got, 1);
    @(posedge clk);
    #1;
    mv[id] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; maddr[i] = '0; mwdata[i] = '0; mwstrb[i] = '0;
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Lone m0 read with a 3-cycle slave and a fixed read value.
    fixed_lat = 3;
    ovr_en = 1'b1;
    ovr_data = 32'hDEADBEEF;
    base = glog.size();
    do_txn(0, 32'h100, 32'h0, 4'h0);
    ovr_en = 1'b0;
    @(negedge clk);
    check("r026_grant_back_idle", grant, 2'b00);
    check("r026_n_grants", glog.size() - base, 1);
    check("r026_grant_m0", glog[base], 2'b01);

    // Spurious completion pulse while idle.
    spur_req++;
    @(negedge clk);
    check("r031_ready_low", {m0_ready, m1_ready}, 2'b00);
    @(negedge clk);
    check("r031_stay_idle", grant, 2'b00);
    @(posedge clk);
    #1;

    // Simultaneous first requests after reset.
    do_reset();
    fixed_lat = 1;
    base = glog.size();
    fork
      do_txn(0, 32'h10, 32'h0, 4'h0);
      do_txn(1, 32'h20, 32'h0, 4'h0);
    join
    check("r027_first", glog[base], RR ? 2'b01 : 2'b10);
    check("r027_second", glog[base+1], RR ? 2'b10 : 2'b01);

    // m1 write with m0 arriving mid-transaction.
    fixed_lat = 4;
    base = glog.size();
    fork
      do_txn(1, 32'h40, 32'h12345678, 4'hF);
      begin
        repeat (2) @(posedge clk);
        #1;
        do_txn(0, 32'h200, 32'h0, 4'h0);
      end
    join
    check("r029_first_m1", glog[base], 2'b10);
    check("r029_then_m0", glog[base+1], 2'b01);

    // Both masters hammering six requests each.
    do_reset();
    fixed_lat = -1;
    base = glog.size();
    fork
      for (int i = 0; i < 6; i++) do_txn(0, $urandom, $urandom, 4'($urandom));
      for (int j = 0; j < 6; j++) do_txn(1, $urandom, $urandom, 4'($urandom));
    join
    check("r028_n_grants", glog.size() - base, 12);
    for (int k = 0; k < 12; k++) begin
      if (RR) check("r028_order_rr", glog[base+k], (k % 2 == 0) ? 2'b01 : 2'b10);
      else    check("r028_order_fixed", glog[base+k], (k < 6) ? 2'b10 : 2'b01);
    end

    // Reset while m1 owns the bus, m0 waiting.
    fixed_lat = 10;
    maddr[1] = 32'h80; mwdata[1] = 32'h0; mwstrb[1] = 4'h0; mv[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant != 2'b10 && n < 20);
    check("r030_gnt1", grant, 2'b10);
    @(posedge clk);
    #1;
    fork
      do_txn(0, 32'h300, 32'hA5, 4'h3);
    join_none
    #2 rst = 1'b0;
    #1;
    check("r030_async_clear", {s_valid, grant, m0_ready, m1_ready}, 0);
    mv[1] = 1'b0;
    fixed_lat = 2;
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("r030_m0_next", grant, 2'b01);
    wait fork;

    // Random traffic on both masters.
    fixed_lat = -1;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        do_txn(0, $urandom, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        do_txn(1, $urandom, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
      end
    join

    repeat (3) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
